// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame loader: parser states,
// command bytes, error codes and the default frame start marker.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CSUM    = 3'd4
    } state_t;

    localparam logic [7:0] CMD_LOAD_A = 8'h01;
    localparam logic [7:0] CMD_LOAD_B = 8'h02;
    localparam logic [7:0] CMD_START  = 8'h03;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_FMT   = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_STATE = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // A command is only legal together with its fixed payload length.
    function automatic logic len_ok(input logic [7:0] cmd,
                                    input logic [7:0] len,
                                    input logic [7:0] elems);
        logic ok;
        case (cmd)
            CMD_LOAD_A, CMD_LOAD_B: ok = (len == elems);
            CMD_START:              ok = (len == 8'd0);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog for the frame loader; compiled only when
// UART_FRAME_LOADER_TIMEOUT_EN is defined.
`ifdef UART_FRAME_LOADER_TIMEOUT_EN
module uart_frame_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic rx_done,
    output logic expire
);

    localparam int              CW    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    // Expiry fires on the edge at which the count would reach the limit.
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        cnt_d   = cnt_q;
        expire  = 1'b0;
        if (!active || rx_done) begin
            cnt_d = '0;
        end else if (cnt_inc == LIMIT) begin
            cnt_d  = '0;
            expire = 1'b1;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/uart_frame_loader.sv
// Frame parser between the UART byte receiver and the systolic array.
// Optional inter-byte timeout: define UART_FRAME_LOADER_TIMEOUT_EN.
module uart_frame_loader
    import uart_frame_pkg::*;
#(
    parameter int         N           = 4,
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              arr_busy,
    output logic              buf_we,
    output logic              buf_sel,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              arr_start,
    output logic              a_valid,
    output logic              b_valid,
    output logic              frame_ok,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [7:0]        ELEMS    = 8'(N * N);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N * N - 1);

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        acc_q, acc_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              buf_we_q, buf_we_d;
    logic              buf_sel_q, buf_sel_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_wdata_q, buf_wdata_d;
    logic              arr_start_q, arr_start_d;
    logic              a_valid_q, a_valid_d;
    logic              b_valid_q, b_valid_d;
    logic              frame_ok_q, frame_ok_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              timeout_s;

`ifdef UART_FRAME_LOADER_TIMEOUT_EN
    uart_frame_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .active (state_q != IDLE),
        .rx_done(rx_done),
        .expire (timeout_s)
    );
`else
    logic unused_timeout_cfg_s;
    assign timeout_s            = 1'b0;
    assign unused_timeout_cfg_s = (TIMEOUT_CYC == 32'sd0);
`endif

    // Parser next-state: every output is computed here and registered below.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        buf_we_d    = 1'b0;
        buf_sel_d   = buf_sel_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        arr_start_d = 1'b0;
        a_valid_d   = a_valid_q;
        b_valid_d   = b_valid_q;
        frame_ok_d  = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;

        if (rx_done) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = CMD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CMD: begin
                    cmd_d   = rx_data;
                    acc_d   = rx_data;
                    state_d = LEN;
                end
                LEN: begin
                    if (!len_ok(cmd_q, rx_data, ELEMS)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_FMT;
                        state_d    = IDLE;
                    end else begin
                        acc_d   = acc_q ^ rx_data;
                        cnt_d   = '0;
                        state_d = (rx_data == 8'd0) ? CSUM : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    buf_we_d    = 1'b1;
                    buf_sel_d   = cmd_q[1];
                    buf_addr_d  = cnt_q;
                    buf_wdata_d = rx_data;
                    acc_d       = acc_q ^ rx_data;
                    cnt_d       = cnt_q + ADDR_W'(1);
                    // Old contents are being overwritten, so the operand is stale from now on.
                    if (cnt_q == '0) begin
                        if (cmd_q[1]) begin
                            b_valid_d = 1'b0;
                        end else begin
                            a_valid_d = 1'b0;
                        end
                    end else begin
                        a_valid_d = a_valid_q;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = CSUM;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                CSUM: begin
                    state_d = IDLE;
                    if (rx_data != acc_q) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end else if (cmd_q == CMD_START) begin
                        if (a_valid_q && b_valid_q && !arr_busy) begin
                            arr_start_d = 1'b1;
                            frame_ok_d  = 1'b1;
                            err_code_d  = ERR_NONE;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_STATE;
                        end
                    end else if (cmd_q == CMD_LOAD_A) begin
                        a_valid_d  = 1'b1;
                        frame_ok_d = 1'b1;
                        err_code_d = ERR_NONE;
                    end else begin
                        b_valid_d  = 1'b1;
                        frame_ok_d = 1'b1;
                        err_code_d = ERR_NONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (timeout_s) begin
            err_d      = 1'b1;
            err_code_d = ERR_STATE;
            state_d    = IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; buffer contents live outside this block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= 8'h00;
            acc_q       <= 8'h00;
            cnt_q       <= '0;
            buf_we_q    <= 1'b0;
            buf_sel_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= 8'h00;
            arr_start_q <= 1'b0;
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            buf_we_q    <= buf_we_d;
            buf_sel_q   <= buf_sel_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            arr_start_q <= arr_start_d;
            a_valid_q   <= a_valid_d;
            b_valid_q   <= b_valid_d;
            frame_ok_q  <= frame_ok_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign buf_we    = buf_we_q;
    assign buf_sel   = buf_sel_q;
    assign buf_addr  = buf_addr_q;
    assign buf_wdata = buf_wdata_q;
    assign arr_start = arr_start_q;
    assign a_valid   = a_valid_q;
    assign b_valid   = b_valid_q;
    assign frame_ok  = frame_ok_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
